timer_periph: RTL and testbench

- APB slave timer peripheral that plugs into the MCU APB fabric as a new slave (PSEL/PRDATA/PREADY slot) next to RAM, GPO, GPI, GPIO, UART and FND.
- Provides a prescaled up-counter with auto-reload, one-shot mode, a sticky update flag and a level interrupt output.
- The CPU configures and polls it through the APB master.

---
 rtl/timer_periph.sv | 155 +++++++++++++++
 tb/tb_timer_periph.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_periph.sv
// timer_periph: APB slave timer with a prescaled up-counter, auto-reload or
// one-shot operation, a sticky update flag (UIF) and a level interrupt.
module timer_periph #(
   parameter int CNT_WIDTH = 32
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic        PWRITE,
   input  logic        PENABLE,
   input  logic [31:0] PWDATA,
   input  logic        PSEL,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        timer_irq
);

   localparam logic [2:0] SEL_CR  = 3'd0;
   localparam logic [2:0] SEL_PSC = 3'd1;
   localparam logic [2:0] SEL_ARR = 3'd2;
   localparam logic [2:0] SEL_CNT = 3'd3;
   localparam logic [2:0] SEL_SR  = 3'd4;

   logic                 cr_en;
   logic                 cr_arpe;
   logic                 cr_ie;
   logic                 sr_uif;
   logic [CNT_WIDTH-1:0] psc;
   logic [CNT_WIDTH-1:0] arr;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] presc;

   logic                 access;
   logic                 wr_en;
   logic                 rd_en;
   logic [2:0]           reg_sel;
   logic                 wr_cr;
   logic                 wr_psc;
   logic                 wr_arr;
   logic                 wr_cnt;
   logic                 wr_sr;
   logic                 clr_req;
   logic                 tick;
   logic                 ovf;
   logic                 upd;
   logic [31:0]          rd_mux;
   logic                 unused_bits;

   // Handshake: a transfer is presented by PSEL with PENABLE marking the access
   // phase. The single cycle where PSEL & PENABLE & !PREADY holds is the one
   // that commits the write / latches the read; PREADY pulses high for exactly
   // the following cycle and the master keeps the transfer asserted until it
   // samples that pulse. PREADY can never be high twice in a row.
   assign access  = PSEL & PENABLE & ~PREADY;
   assign wr_en   = access & PWRITE;
   assign rd_en   = access & ~PWRITE;
   assign reg_sel = PADDR[4:2];

   assign wr_cr   = wr_en & (reg_sel == SEL_CR);
   assign wr_psc  = wr_en & (reg_sel == SEL_PSC);
   assign wr_arr  = wr_en & (reg_sel == SEL_ARR);
   assign wr_cnt  = wr_en & (reg_sel == SEL_CNT);
   assign wr_sr   = wr_en & (reg_sel == SEL_SR);
   assign clr_req = wr_cr & PWDATA[3];

   assign tick = cr_en & (presc == psc);
   assign ovf  = tick & (cnt == arr);
   // A software CNT write or CLR in the same cycle supersedes the update event.
   assign upd  = ovf & ~wr_cnt & ~clr_req;

   assign timer_irq = sr_uif & cr_ie;

   assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         SEL_CR:  rd_mux[2:0]           = {cr_ie, cr_arpe, cr_en};
         SEL_PSC: rd_mux[CNT_WIDTH-1:0] = psc;
         SEL_ARR: rd_mux[CNT_WIDTH-1:0] = arr;
         SEL_CNT: rd_mux[CNT_WIDTH-1:0] = cnt;
         SEL_SR:  rd_mux[0]             = sr_uif;
         default: rd_mux                = '0;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         PREADY <= 1'b0;
         PRDATA <= '0;
      end else begin
         PREADY <= access;
         if (rd_en) begin
            PRDATA <= rd_mux;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         cr_en   <= 1'b0;
         cr_arpe <= 1'b0;
         cr_ie   <= 1'b0;
         psc     <= '0;
         arr     <= '1;
      end else begin
         if (wr_cr) begin
            cr_en   <= PWDATA[0];
            cr_arpe <= PWDATA[1];
            cr_ie   <= PWDATA[2];
         end else if (upd && !cr_arpe) begin
            cr_en <= 1'b0;
         end
         if (wr_psc) begin
            psc <= PWDATA[CNT_WIDTH-1:0];
         end
         if (wr_arr) begin
            arr <= PWDATA[CNT_WIDTH-1:0];
         end
      end
   end

   // CNT above ARR never matches, so it rolls through all ones to 0 silently.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         cnt   <= '0;
         presc <= '0;
      end else if (clr_req) begin
         cnt   <= '0;
         presc <= '0;
      end else begin
         if (wr_cnt) begin
            cnt <= PWDATA[CNT_WIDTH-1:0];
         end else if (tick) begin
            cnt <= (cnt == arr) ? '0 : cnt + CNT_WIDTH'(1);
         end
         if (tick) begin
            presc <= '0;
         end else if (cr_en) begin
            presc <= presc + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         sr_uif <= 1'b0;
      end else if (upd) begin
         sr_uif <= 1'b1;
      end else if (wr_sr && PWDATA[0]) begin
         sr_uif <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timer_periph.sv
// Directed testbench for timer_periph: APB register access, prescaled counting,
// one-shot, interrupt/flag priority, CLR, wrap-around and mid-transfer reset.
module tb_timer_periph;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic        PSEL;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        timer_irq;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;

   logic [2:0]  hs;
   logic        irq_mid;
   logic [31:0] rdata;
   int          ecyc;

   timer_periph #(.CNT_WIDTH(32)) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PENABLE   (PENABLE),
      .PWDATA    (PWDATA),
      .PSEL      (PSEL),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .timer_irq (timer_irq)
   );

   // clock / reset
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc = cyc + 1;

   // drivers: start and end on a falling edge; ecyc = edge count of the access edge
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
      @(negedge PCLK); hs[2] = PREADY; PENABLE = 1'b1;
      @(negedge PCLK); hs[1] = PREADY; irq_mid = timer_irq; ecyc = cyc;
      @(negedge PCLK); hs[0] = PREADY; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
      @(negedge PCLK); hs[2] = PREADY; PENABLE = 1'b1;
      @(negedge PCLK); hs[1] = PREADY; rdata = PRDATA; ecyc = cyc;
      @(negedge PCLK); hs[0] = PREADY; PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_r [0:4];
      exp_r[0] = 32'h0; exp_r[1] = 32'h0; exp_r[2] = 32'hFFFF_FFFF;
      exp_r[3] = 32'h0; exp_r[4] = 32'h0;
      n_vec++;
      if (PREADY !== 1'b0) begin n_err++; $display("FAIL rst_pready: got %b exp 0", PREADY); end
      n_vec++;
      if (PRDATA !== 32'h0) begin n_err++; $display("FAIL rst_prdata: got %h exp 0", PRDATA); end
      n_vec++;
      if (timer_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b exp 0", timer_irq); end
      @(negedge PCLK); PRESET = 1'b1;
      @(negedge PCLK);
      for (int i = 0; i < 5; i++) begin
         apb_read(32'(i * 4));
         n_vec++;
         if (rdata !== exp_r[i]) begin
            n_err++; $display("FAIL rst_reg%0d: got %h exp %h", i, rdata, exp_r[i]);
         end
         n_vec++;
         if (hs !== 3'b010) begin
            n_err++; $display("FAIL rst_hs%0d: got %b exp 010", i, hs);
         end
      end
      apb_write(32'h14, 32'hFFFF_FFFF);
      apb_read(32'h1C);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h exp 0", rdata); end
      apb_read(32'h00);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL unmapped_wr: got %h exp 0", rdata); end
   endtask

   task automatic test_count();
      int c0;
      int first;
      int n;
      logic [31:0] exp_cnt;
      apb_write(32'h04, 32'd3);
      apb_write(32'h08, 32'd4);
      apb_write(32'h00, 32'h7);
      c0 = ecyc;
      n_vec++;
      if (hs !== 3'b010) begin n_err++; $display("FAIL wr_hs: got %b exp 010", hs); end
      first = -1;
      while (cyc < c0 + 25) begin
         @(negedge PCLK);
         if (timer_irq === 1'b1 && first < 0) first = cyc - c0;
      end
      n_vec++;
      if (first != 20) begin n_err++; $display("FAIL uif_first: got %0d exp 20", first); end
      for (int k = 0; k < 6; k++) begin
         apb_read(32'h0C);
         n = ecyc - 1 - c0;
         exp_cnt = 32'((n / 4) % 5);
         n_vec++;
         if (rdata !== exp_cnt) begin
            n_err++; $display("FAIL cnt_run%0d: got %h exp %h", k, rdata, exp_cnt);
         end
      end
      apb_read(32'h10);
      n_vec++;
      if (rdata !== 32'h1) begin n_err++; $display("FAIL count_sr: got %h exp 1", rdata); end
      apb_write(32'h00, 32'h8);
      apb_write(32'h10, 32'h1);
   endtask

   task automatic test_oneshot();
      int c0;
      apb_write(32'h04, 32'd0);
      apb_write(32'h08, 32'd2);
      apb_write(32'h00, 32'h1);
      c0 = ecyc;
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd2) begin n_err++; $display("FAIL os_cnt2: got %h exp 2 (n=%0d)", rdata, ecyc - 1 - c0); end
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd0) begin n_err++; $display("FAIL os_cnt0: got %h exp 0", rdata); end
      apb_read(32'h10);
      n_vec++;
      if (rdata !== 32'h1) begin n_err++; $display("FAIL os_uif: got %h exp 1", rdata); end
      apb_read(32'h00);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL os_cr: got %h exp 0", rdata); end
      repeat (10) @(negedge PCLK);
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd0) begin n_err++; $display("FAIL os_hold: got %h exp 0", rdata); end
   endtask

   task automatic test_irq();
      n_vec++;
      if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b exp 0", timer_irq); end
      apb_write(32'h00, 32'h4);
      n_vec++;
      if (irq_mid !== 1'b1) begin n_err++; $display("FAIL irq_on: got %b exp 1", irq_mid); end
      apb_write(32'h10, 32'h1);
      n_vec++;
      if (irq_mid !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b exp 0", irq_mid); end
      // ARR = 0 and PSC = 0 make every cycle an overflow tick
      apb_write(32'h08, 32'd0);
      apb_write(32'h00, 32'h7);
      apb_write(32'h10, 32'h1);
      n_vec++;
      if (irq_mid !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b exp 1", irq_mid); end
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd0) begin n_err++; $display("FAIL arr0_cnt: got %h exp 0", rdata); end
      apb_write(32'h00, 32'h8);
      apb_write(32'h10, 32'h1);
      apb_read(32'h10);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL irq_sr_off: got %h exp 0", rdata); end
   endtask

   task automatic test_clear_wrap();
      int c0;
      apb_write(32'h04, 32'd9);
      apb_write(32'h08, 32'd100);
      apb_write(32'h00, 32'h3);
      apb_write(32'h0C, 32'd50);
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd50) begin n_err++; $display("FAIL cnt_wr: got %h exp 50", rdata); end
      apb_write(32'h00, 32'hB);
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd0) begin n_err++; $display("FAIL clr_cnt: got %h exp 0", rdata); end
      apb_read(32'h00);
      n_vec++;
      if (rdata !== 32'h3) begin n_err++; $display("FAIL clr_cr: got %h exp 3", rdata); end
      apb_write(32'h00, 32'h8);
      apb_write(32'h04, 32'd0);
      apb_write(32'h10, 32'h1);
      apb_write(32'h0C, 32'hFFFF_FFFD);
      apb_write(32'h00, 32'h3);
      c0 = ecyc;
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_top: got %h exp ffffffff (n=%0d)", rdata, ecyc - 1 - c0); end
      apb_read(32'h0C);
      n_vec++;
      if (rdata !== 32'd2) begin n_err++; $display("FAIL wrap_low: got %h exp 2", rdata); end
      apb_read(32'h10);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL wrap_nouif: got %h exp 0", rdata); end
      apb_write(32'h00, 32'h8);
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_r [0:4];
      exp_r[0] = 32'h0; exp_r[1] = 32'h0; exp_r[2] = 32'hFFFF_FFFF;
      exp_r[3] = 32'h0; exp_r[4] = 32'h0;
      apb_write(32'h08, 32'd0);
      apb_write(32'h00, 32'h7);
      n_vec++;
      if (timer_irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq: got %b exp 1", timer_irq); end
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h55;
      @(negedge PCLK); PENABLE = 1'b1; PRESET = 1'b0;
      #1;
      n_vec++;
      if (PREADY !== 1'b0) begin n_err++; $display("FAIL mid_pready: got %b exp 0", PREADY); end
      n_vec++;
      if (timer_irq !== 1'b0) begin n_err++; $display("FAIL mid_irq: got %b exp 0", timer_irq); end
      n_vec++;
      if (PRDATA !== 32'h0) begin n_err++; $display("FAIL mid_prdata: got %h exp 0", PRDATA); end
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(negedge PCLK); PRESET = 1'b1;
      @(negedge PCLK);
      for (int i = 0; i < 5; i++) begin
         apb_read(32'(i * 4));
         n_vec++;
         if (rdata !== exp_r[i]) begin
            n_err++; $display("FAIL mid_reg%0d: got %h exp %h", i, rdata, exp_r[i]);
         end
      end
   endtask

   initial begin
      PRESET = 1'b0; PADDR = '0; PWRITE = 1'b0; PENABLE = 1'b0; PWDATA = '0; PSEL = 1'b0;
      hs = '0; irq_mid = 1'b0; rdata = '0; ecyc = 0;
      @(negedge PCLK);
      test_reset();
      test_count();
      test_oneshot();
      test_irq();
      test_clear_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
